// File: rtl/pkt_rr_arbiter.sv
// Packet-granular two-to-one round-robin arbiter.
// Forwards whole packets from two byte-stream sources to one sink. It never
// interleaves the beats of two packets. Each output beat is registered and
// tagged with the channel it came from.
//
// Optional feature (macro PKT_ARB_LEN_GUARD_EN): a packet longer than MAX_LEN
// beats is cut at beat MAX_LEN, and that beat gets a forced sink_last. The
// rest of the packet is then absorbed in DRAIN, and len_err pulses for one
// cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   src_data/valid/last/ready{1,2}  source channels (ready is combinational)
//   sink_data/valid/last/id  registered output beat, id 0 = ch1, 1 = ch2
//   sink_ready               downstream accept
//   busy                     high while a packet is granted
//   pkt_cnt1, pkt_cnt2       completed packets per channel (wrapping)
//   len_err                  truncation pulse (only with PKT_ARB_LEN_GUARD_EN)
module pkt_rr_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_LEN = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] src_data1,
  input  logic              src_valid1,
  input  logic              src_last1,
  output logic              src_ready1,
  input  logic [DATA_W-1:0] src_data2,
  input  logic              src_valid2,
  input  logic              src_last2,
  output logic              src_ready2,
  output logic [DATA_W-1:0] sink_data,
  output logic              sink_valid,
  output logic              sink_last,
  output logic              sink_id,
  input  logic              sink_ready,
  output logic              busy,
`ifdef PKT_ARB_LEN_GUARD_EN
  output logic              len_err,
`endif
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic [CNT_W-1:0]  pkt_cnt2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              grant, grant_n;           // 0 = ch1, 1 = ch2
  logic              last_grant, last_grant_n;
  logic              can_load;
  logic              gnt_ready;
  logic              load;
  logic              trunc;
  logic              sel_valid, sel_last, accept, last_acc;
  logic [DATA_W-1:0] sel_data;

  // Granted channel's view of its source.
  assign sel_valid = grant ? src_valid2 : src_valid1;
  assign sel_last  = grant ? src_last2  : src_last1;
  assign sel_data  = grant ? src_data2  : src_data1;

  // The output register can take a new beat when it is empty or being drained.
  assign can_load = !sink_valid || sink_ready;

  assign src_ready1 = gnt_ready && !grant;
  assign src_ready2 = gnt_ready &&  grant;
  assign busy       = (state != IDLE);
  assign accept     = sel_valid && gnt_ready;
  assign last_acc   = accept && sel_last;

`ifdef PKT_ARB_LEN_GUARD_EN
  localparam int unsigned BEAT_W = $clog2(MAX_LEN + 1);

  logic [BEAT_W-1:0] beat_cnt;

  // Beats accepted in the current grant; cleared while arbitrating.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= trunc;
      if (state == IDLE) begin
        beat_cnt <= '0;
      end else if (load) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end
`else
  // MAX_LEN has no effect unless the length guard is built in.
  if (MAX_LEN == 0) begin : g_max_len_unused
  end
`endif

  // Arbitration and packet-tracking next state.
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    gnt_ready    = 1'b0;
    load         = 1'b0;
    trunc        = 1'b0;
    case (state)
      IDLE: begin
        if (src_valid1 || src_valid2) begin
          // On a contest, the channel not served last wins.
          grant_n      = (src_valid1 && src_valid2) ? ~last_grant : src_valid2;
          last_grant_n = grant_n;
          state_n      = BUSY;
        end
      end
      BUSY: begin
        gnt_ready = can_load;
        if (sel_valid && can_load) begin
          load = 1'b1;
          if (sel_last) begin
            state_n = IDLE;
          end
`ifdef PKT_ARB_LEN_GUARD_EN
          else if (beat_cnt == BEAT_W'(MAX_LEN - 1)) begin
            trunc   = 1'b1;
            state_n = DRAIN;
          end
`endif
        end
      end
      DRAIN: begin
        // Swallow the oversized tail; nothing reaches the sink.
        gnt_ready = 1'b1;
        if (sel_valid && sel_last) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, output beat register and packet counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      sink_data  <= '0;
      sink_valid <= 1'b0;
      sink_last  <= 1'b0;
      sink_id    <= 1'b0;
      pkt_cnt1   <= '0;
      pkt_cnt2   <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      if (load) begin
        sink_data  <= sel_data;
        sink_last  <= sel_last || trunc;
        sink_id    <= grant;
        sink_valid <= 1'b1;
      end else if (sink_ready) begin
        sink_valid <= 1'b0;
      end
      if (last_acc && !grant) begin
        pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end
      if (last_acc && grant) begin
        pkt_cnt2 <= pkt_cnt2 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Testbench for pkt_rr_arbiter: a table of per-cycle vectors plus
// hand-written sequences for arbitration, back-pressure and the length guard.
module tb_pkt_rr_arbiter;

`ifdef PKT_ARB_LEN_GUARD_EN
  localparam int unsigned TB_MAX_LEN = 4;
`else
  localparam int unsigned TB_MAX_LEN = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src_data1, src_data2, sink_data;
  logic        src_valid1, src_last1, src_ready1;
  logic        src_valid2, src_last2, src_ready2;
  logic        sink_valid, sink_last, sink_id, sink_ready, busy;
  logic [15:0] pkt_cnt1, pkt_cnt2;
`ifdef PKT_ARB_LEN_GUARD_EN
  logic        len_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pkt_rr_arbiter #(.DATA_W(8), .CNT_W(16), .MAX_LEN(TB_MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .src_data1(src_data1), .src_valid1(src_valid1), .src_last1(src_last1), .src_ready1(src_ready1),
    .src_data2(src_data2), .src_valid2(src_valid2), .src_last2(src_last2), .src_ready2(src_ready2),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_last(sink_last), .sink_id(sink_id),
    .sink_ready(sink_ready), .busy(busy),
`ifdef PKT_ARB_LEN_GUARD_EN
    .len_err(len_err),
`endif
    .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2)
  );

  typedef struct {
    logic       rst, v1, l1;
    logic [7:0] d1;
    logic       v2, l2;
    logic [7:0] d2;
    logic       sr;
    logic       sv;
    logic [7:0] sd;
    logic       sl, sid, r1, r2, b;
    logic [15:0] c1, c2;
  } vec_t;

  vec_t vecs[$];
  logic [9:0] got[$];

  function automatic vec_t mk(input logic rst_i, input logic v1_i, input logic l1_i,
                              input logic [7:0] d1_i, input logic v2_i, input logic l2_i,
                              input logic [7:0] d2_i, input logic sr_i, input logic sv_i,
                              input logic [7:0] sd_i, input logic sl_i, input logic sid_i,
                              input logic r1_i, input logic r2_i, input logic b_i,
                              input logic [15:0] c1_i, input logic [15:0] c2_i);
    vec_t v;
    v.rst = rst_i; v.v1 = v1_i; v.l1 = l1_i; v.d1 = d1_i;
    v.v2 = v2_i; v.l2 = l2_i; v.d2 = d2_i; v.sr = sr_i;
    v.sv = sv_i; v.sd = sd_i; v.sl = sl_i; v.sid = sid_i;
    v.r1 = r1_i; v.r2 = r2_i; v.b = b_i; v.c1 = c1_i; v.c2 = c2_i;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    src_valid1 = 1'b0; src_last1 = 1'b0; src_data1 = 8'h00;
    src_valid2 = 1'b0; src_last2 = 1'b0; src_data2 = 8'h00;
    sink_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [45:0] act, exp;
    int i1, i2, pk1, pk2, errs;
    logic gap_pend, hold_v;
    logic [7:0] held;
    logic [9:0] e;

    rst = 1'b1;
    idle_inputs();
    do_reset();
    #1;
    check("reset_state",
          {src_ready1, src_ready2, busy, sink_valid, sink_last, sink_id, sink_data, pkt_cnt1, pkt_cnt2},
          '0);

    // rst v1 l1 d1 v2 l2 d2 sr | sv sd sl sid r1 r2 b c1 c2
    // 4-beat ch1 packet
    vecs.push_back(mk(0,1,0,8'h11,0,0,8'h00,1, 0,8'h00,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,8'h11,0,0,8'h00,1, 0,8'h00,0,0,1,0,1,0,0));
    vecs.push_back(mk(0,1,0,8'h12,0,0,8'h00,1, 1,8'h11,0,0,1,0,1,0,0));
    vecs.push_back(mk(0,1,0,8'h13,0,0,8'h00,1, 1,8'h12,0,0,1,0,1,0,0));
    vecs.push_back(mk(0,1,1,8'h14,0,0,8'h00,1, 1,8'h13,0,0,1,0,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00,0,0,8'h00,1, 1,8'h14,1,0,0,0,0,1,0));
    vecs.push_back(mk(0,0,0,8'h00,0,0,8'h00,1, 0,8'h00,0,0,0,0,0,1,0));
    // reset, then three single-beat ch1 packets
    vecs.push_back(mk(1,0,0,8'h00,0,0,8'h00,1, 0,8'h00,0,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,1,8'hAA,0,0,8'h00,1, 0,8'h00,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,1,8'hAA,0,0,8'h00,1, 0,8'h00,0,0,1,0,1,0,0));
    vecs.push_back(mk(0,1,1,8'hAA,0,0,8'h00,1, 1,8'hAA,1,0,0,0,0,1,0));
    vecs.push_back(mk(0,1,1,8'hAA,0,0,8'h00,1, 0,8'h00,0,0,1,0,1,1,0));
    vecs.push_back(mk(0,1,1,8'hAA,0,0,8'h00,1, 1,8'hAA,1,0,0,0,0,2,0));
    vecs.push_back(mk(0,1,1,8'hAA,0,0,8'h00,1, 0,8'h00,0,0,1,0,1,2,0));
    vecs.push_back(mk(0,0,0,8'h00,0,0,8'h00,1, 1,8'hAA,1,0,0,0,0,3,0));
    vecs.push_back(mk(0,0,0,8'h00,0,0,8'h00,1, 0,8'h00,0,0,0,0,0,3,0));
    // reset while the 2nd ch1 beat is stalled at the sink
    vecs.push_back(mk(0,1,0,8'h21,0,0,8'h00,0, 0,8'h00,0,0,0,0,0,3,0));
    vecs.push_back(mk(0,1,0,8'h21,0,0,8'h00,0, 0,8'h00,0,0,1,0,1,3,0));
    vecs.push_back(mk(0,1,0,8'h22,0,0,8'h00,1, 1,8'h21,0,0,1,0,1,3,0));
    vecs.push_back(mk(1,1,0,8'h23,0,0,8'h00,0, 1,8'h22,0,0,0,0,1,3,0));
    vecs.push_back(mk(0,0,0,8'h00,1,0,8'h31,1, 0,8'h00,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,8'h00,1,0,8'h31,1, 0,8'h00,0,0,0,1,1,0,0));
    vecs.push_back(mk(0,0,0,8'h00,1,1,8'h32,1, 1,8'h31,0,1,0,1,1,0,0));
    // contest afterwards: ch1 must win
    vecs.push_back(mk(0,1,1,8'h41,1,1,8'h51,1, 1,8'h32,1,1,0,0,0,0,1));
    vecs.push_back(mk(0,1,1,8'h41,1,1,8'h51,1, 0,8'h00,0,0,1,0,1,0,1));
    vecs.push_back(mk(0,0,0,8'h00,1,1,8'h51,1, 1,8'h41,1,0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,8'h00,1,1,8'h51,1, 0,8'h00,0,0,0,1,1,1,1));
    vecs.push_back(mk(0,0,0,8'h00,0,0,8'h00,1, 1,8'h51,1,1,0,0,0,1,2));
    vecs.push_back(mk(0,0,0,8'h00,0,0,8'h00,1, 0,8'h00,0,0,0,0,0,1,2));

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst;
      src_valid1 = vecs[k].v1; src_last1 = vecs[k].l1; src_data1 = vecs[k].d1;
      src_valid2 = vecs[k].v2; src_last2 = vecs[k].l2; src_data2 = vecs[k].d2;
      sink_ready = vecs[k].sr;
      #1;
      act = {sink_valid, sink_valid ? sink_data : 8'h00, sink_valid & sink_last,
             sink_valid & sink_id, src_ready1, src_ready2, busy, pkt_cnt1, pkt_cnt2};
      exp = {vecs[k].sv, vecs[k].sv ? vecs[k].sd : 8'h00, vecs[k].sv & vecs[k].sl,
             vecs[k].sv & vecs[k].sid, vecs[k].r1, vecs[k].r2, vecs[k].b, vecs[k].c1, vecs[k].c2};
      check($sformatf("vec%0d", k), 64'(act), 64'(exp));
    end

    // Both channels stream 3-beat packets from reset: ch1, ch2, ch1, ch2.
    do_reset();
    i1 = 0; i2 = 0; pk1 = 0; pk2 = 0; gap_pend = 1'b0;
    got.delete();
    for (int cyc = 0; cyc < 60 && got.size() < 12; cyc++) begin
      @(negedge clk);
      src_valid1 = (pk1 < 2); src_data1 = 8'(8'hA0 + pk1 * 4 + i1); src_last1 = (i1 == 2);
      src_valid2 = (pk2 < 2); src_data2 = 8'(8'hC0 + pk2 * 4 + i2); src_last2 = (i2 == 2);
      sink_ready = 1'b1;
      #1;
      if (gap_pend) begin
        check("rr_gap", 64'({src_ready1, src_ready2}), 64'(0));
        gap_pend = 1'b0;
      end
      if (sink_valid) got.push_back({sink_id, sink_last, sink_data});
      if (src_valid1 && src_ready1) begin
        if (i1 == 2) begin i1 = 0; pk1++; gap_pend = 1'b1; end else i1++;
      end
      if (src_valid2 && src_ready2) begin
        if (i2 == 2) begin i2 = 0; pk2++; gap_pend = 1'b1; end else i2++;
      end
    end
    check("rr_beats", 64'(got.size()), 64'(12));
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 3; b++) begin
        e = {1'(p % 2), 1'(b == 2), 8'(((p % 2) != 0 ? 8'hC0 : 8'hA0) + (p / 2) * 4 + b)};
        if (p * 3 + b < got.size())
          check($sformatf("rr_p%0d_b%0d", p, b), 64'(got[p * 3 + b]), 64'(e));
        else
          check($sformatf("rr_p%0d_b%0d", p, b), 64'hFFFF, 64'(e));
      end
    end
    check("rr_counts", 64'({pkt_cnt1, pkt_cnt2}), 64'({16'd2, 16'd2}));

`ifndef PKT_ARB_LEN_GUARD_EN
    // ch2 5-beat packet with sink_ready toggling 1,0,1,0...
    do_reset();
    i2 = 0; hold_v = 1'b0; held = 8'h00;
    got.delete();
    for (int cyc = 0; cyc < 60 && got.size() < 5; cyc++) begin
      @(negedge clk);
      sink_ready = ((cyc % 2) == 0);
      src_valid1 = 1'b0;
      src_valid2 = (i2 < 5); src_data2 = 8'(8'h60 + i2); src_last2 = (i2 == 4);
      #1;
      if (hold_v && sink_valid) check("bp_stable", 64'(sink_data), 64'(held));
      hold_v = 1'b0;
      if (sink_valid && !sink_ready) begin
        check("bp_ready_low", 64'(src_ready2), 64'(0));
        held   = sink_data;
        hold_v = 1'b1;
      end
      if (sink_valid && sink_ready) got.push_back({sink_id, sink_last, sink_data});
      if (src_valid2 && src_ready2) i2++;
    end
    check("bp_beats", 64'(got.size()), 64'(5));
    for (int b = 0; b < 5 && b < got.size(); b++)
      check($sformatf("bp_b%0d", b), 64'(got[b]), 64'({1'b1, 1'(b == 4), 8'(8'h60 + b)}));
    check("bp_cnt2", 64'(pkt_cnt2), 64'(1));
`else
    // Oversized ch1 packet is cut at MAX_LEN, then ch2 is served.
    do_reset();
    i1 = 0; errs = 0;
    got.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      sink_ready = 1'b1;
      src_valid1 = (i1 < 7); src_data1 = 8'(8'h71 + i1); src_last1 = (i1 == 6);
      src_valid2 = (i1 >= 7) && (pkt_cnt2 == 16'd0) && !(sink_valid && sink_id);
      src_data2 = 8'h90; src_last2 = 1'b1;
      #1;
      if (len_err) errs++;
      if (sink_valid) got.push_back({sink_id, sink_last, sink_data});
      if (src_valid1 && src_ready1) i1++;
    end
    check("lg_beats", 64'(got.size()), 64'(5));
    for (int b = 0; b < 4 && b < got.size(); b++)
      check($sformatf("lg_b%0d", b), 64'(got[b]), 64'({1'b0, 1'(b == 3), 8'(8'h71 + b)}));
    if (got.size() > 4) check("lg_ch2", 64'(got[4]), 64'({1'b1, 1'b1, 8'h90}));
    check("lg_err_pulses", 64'(errs), 64'(1));
    check("lg_counts", 64'({pkt_cnt1, pkt_cnt2}), 64'({16'd1, 16'd1}));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
- Packet-granular two-to-one arbiter. Shares a single downstream byte-stream sink between two packet sources, such as the two sync output channels or two capture streams.
- Grants whole packets round-robin, from first beat to the beat with last.
- Never interleaves beats of two packets.
- Registers the output beat and tags it with the source channel.

Parameters:
- DATA_W, 8, data beat width in bits
- CNT_W, 16, width of the per-channel packet counters
- MAX_LEN, 255, maximum beats per packet; used only with the optional feature

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- src_data1  in  DATA_W  channel 1 beat data
- src_valid1  in  1  channel 1 beat valid
- src_last1  in  1  channel 1 final beat of packet
- src_ready1  out  1  channel 1 beat accepted when high with src_valid1
- src_data2  in  DATA_W  channel 2 beat data
- src_valid2  in  1  channel 2 beat valid
- src_last2  in  1  channel 2 final beat of packet
- src_ready2  out  1  channel 2 accept
- sink_data  out  DATA_W  output beat data
- sink_valid  out  1  output beat valid
- sink_last  out  1  output final beat
- sink_id  out  1  0 = beat from channel 1, 1 = beat from channel 2
- sink_ready  in  1  downstream accept
- busy  out  1  high while a packet is granted
- pkt_cnt1  out  CNT_W  completed channel 1 packets
- pkt_cnt2  out  CNT_W  completed channel 2 packets

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all outputs are 0, including sink_data, sink_valid, sink_last, sink_id, src_ready1, src_ready2, busy, pkt_cnt1 and pkt_cnt2. Internal last_grant resets to channel 2, so channel 1 wins the first contest.
- Reset mid-packet: the output register is cleared immediately. A partially forwarded packet is abandoned with no sink_last. Sources must restart.
- FSM states:
  - IDLE: src_ready1 = src_ready2 = 0, busy = 0.
  - If only one src_valid is high, grant that channel.
  - If both are high, grant the channel other than last_grant.
  - If neither is high, stay in IDLE.
  - On any grant: register grant, set last_grant = grant, go to BUSY. This takes 1 cycle.
  - BUSY: busy = 1.
  - src_readyN = (grant==N) && (!sink_valid || sink_ready). This is combinational from registered state and sink_ready.
  - Non-granted channel ready = 0.
  - Leave BUSY for IDLE on the cycle a beat with src_last is accepted.
- Output register:
  - On accept (src_validN && src_readyN): load sink_data, sink_last and sink_id = grant, and set sink_valid = 1.
  - Else if sink_ready: sink_valid = 0.
  - Outputs hold stable while sink_valid && !sink_ready.
- Throughput and latency:
  - Full rate, one beat per cycle, within a packet when sink_ready is held high.
  - Input accept to sink_valid: 1 cycle.
  - Minimum 1 input-side idle cycle between packets (IDLE arbitration cycle).
  - Packet latency from src_valid in IDLE to first sink_valid: 2 cycles.
- Counters: pkt_cntN increments by 1 when a last beat of channel N is accepted from the source. Wraps modulo 2^CNT_W with no saturation.
- Single-beat packet (valid and last on the first beat): granted, accepted, back to IDLE next cycle.
- A source dropping src_valid mid-packet keeps the grant. The arbiter waits indefinitely with no timeout.
- src_last is ignored when src_valid is low.
- src_data and src_last of the non-granted channel are ignored.

Optional Feature:
- Macro: PKT_ARB_LEN_GUARD_EN.
- When defined:
  - A beat counter per grant, width ceil(log2(MAX_LEN+1)), counts accepted beats.
  - If beat MAX_LEN is accepted without src_last, the arbiter forces sink_last = 1 on that output beat.
  - It then enters state DRAIN. In DRAIN it holds src_readyN = 1 for the granted channel and discards beats, with no sink_valid, until a src_last beat is accepted. Then it goes to IDLE.
  - The packet is still counted in pkt_cntN.
  - Output port len_err (1 bit) pulses high for 1 cycle when truncation occurs. It resets to 0.
- When undefined: no beat counter, no DRAIN state, no len_err port. Packets of any length pass unmodified.

Test Plan:
- Ch1 sends 4-beat packet 0x11..0x14, ch2 idle, sink_ready=1 -> sink shows 0x11..0x14, sink_id=0, sink_last on 0x14, first sink_valid 2 cycles after src_valid1, pkt_cnt1=1.
- Both channels present 3-beat packets continuously, straight after reset -> order is ch1, ch2, ch1, ch2; never interleaved; one idle input cycle between packets; pkt_cnt1 = pkt_cnt2 after each pair.
- Ch2 5-beat packet, sink_ready toggled 1010... -> every beat appears exactly once, in order; sink_data stable while sink_valid && !sink_ready; src_ready2 low in those cycles.
- Ch1 single-beat packet 0xAA with last, repeated 3 times -> three sink beats each with sink_last=1; busy pulses 1 cycle per packet; pkt_cnt1=3.
- Assert rst while the 2nd beat of a ch1 packet is pending at the sink -> next cycle all outputs are 0 and the FSM is in IDLE; a following ch2 packet is granted normally; ch1 is granted first on a subsequent contest.
- With PKT_ARB_LEN_GUARD_EN and MAX_LEN=4, ch1 sends 7-beat packet -> sink gets 4 beats, last on beat 4; len_err pulses once; beats 5-7 are absorbed; pkt_cnt1=1; ch2 is granted afterwards.
